// File: rtl/bcd_time_display.sv
// BCD mm:ss / hh:mm:ss timekeeper with self-generated tick, validated loads,
// alarm match and a registered, multiplexed active-low 7-segment scanner.
module bcd_time_display #(
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 65536,
    parameter int DIGITS   = 4
) (
    input  logic                  clk_osc,
    input  logic                  reset,
    input  logic                  run_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_value_i,
    input  logic [4*DIGITS-1:0]   alarm_value_i,
    input  logic                  alarm_en_i,
    input  logic                  alarm_ack_i,
    input  logic [DIGITS-1:0]     blink_mask_i,
    output logic [4*DIGITS-1:0]   time_out_o,
    output logic                  tick_o,
    output logic                  load_err_o,
    output logic                  alarm_hit_o,
    output logic                  alarm_active_o,
    output logic [DIGITS-1:0]     an_n_o,
    output logic [6:0]            seg_n_o
);

    localparam int TW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic SIX = (DIGITS == 6);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]    D_LAST = 3'(DIGITS - 1);

    // Time is handled as a zero-extended 24-bit hh:mm:ss word; 4-digit mode
    // simply never carries into the hour nibbles.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t, input logic six);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else if (t[7:4] != 4'd5) begin
            r[3:0] = 4'd0;
            r[7:4] = t[7:4] + 4'd1;
        end else if (t[11:8] != 4'd9) begin
            r[7:0]  = 8'h00;
            r[11:8] = t[11:8] + 4'd1;
        end else if (t[15:12] != 4'd5) begin
            r[11:0]  = 12'h000;
            r[15:12] = t[15:12] + 4'd1;
        end else if (!six || (t[23:16] == 8'h23)) begin
            r = 24'h000000;
        end else if (t[19:16] == 4'd9) begin
            r[19:0]  = 20'h00000;
            r[23:20] = t[23:20] + 4'd1;
        end else begin
            r[15:0]  = 16'h0000;
            r[19:16] = t[19:16] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [23:0] t, input logic six);
        logic mmss_ok;
        logic hh_ok;
        mmss_ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
                  (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5);
        hh_ok   = (t[19:16] <= 4'd9) &&
                  ((t[23:20] < 4'd2) || ((t[23:20] == 4'd2) && (t[19:16] <= 4'd3)));
        return mmss_ok && (!six || hh_ok);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   c_q, c_d;
    logic [2:0]      d_q, d_d;
    logic [TW-1:0]   time_q, time_d;
    logic            tick_q, tick_d;
    logic            load_err_q, load_err_d;
    logic            inc_q, inc_d;
    logic            alarm_hit_q, alarm_hit_d;
    logic            alarm_active_q, alarm_active_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    logic [6:0]      seg_n_q, seg_n_d;

    logic            wrap_s;
    logic            load_ok_s;
    logic            blink_off_s;
    logic            blank_s;
    logic [3:0]      digit_s;

    // Next-state logic for timebase, time, alarm, scan and display.
    always_comb begin
        wrap_s    = run_i && (p_q == P_LAST);
        load_ok_s = load_i && bcd_valid(24'(load_value_i), SIX);

        time_d = time_q;
        if (load_ok_s) begin
            time_d = load_value_i;
        end else if (wrap_s) begin
            time_d = TW'(bcd_inc(24'(time_q), SIX));
        end else begin
            time_d = time_q;
        end

        if (load_ok_s || wrap_s) begin
            p_d = '0;
        end else if (run_i) begin
            p_d = p_q + PW'(1);
        end else begin
            p_d = p_q;
        end

        tick_d     = wrap_s;
        load_err_d = load_i && !load_ok_s;
        inc_d      = wrap_s && !load_ok_s;

        // Compare one cycle after a tick-driven update so loads never match.
        alarm_hit_d    = inc_q && alarm_en_i && (time_q == alarm_value_i);
        alarm_active_d = alarm_hit_d || (alarm_active_q && !alarm_ack_i);

        if (c_q == C_LAST) begin
            c_d = '0;
            d_d = (d_q == D_LAST) ? 3'd0 : d_q + 3'd1;
        end else begin
            c_d = c_q + CW'(1);
            d_d = d_q;
        end

        blink_off_s = (p_q >= P_HALF);
        blank_s     = blink_off_s && 1'(blink_mask_i >> d_q);
        digit_s     = 4'(time_q >> {d_q, 2'b00});
        an_n_d      = blank_s ? {DIGITS{1'b1}} : ~(DIGITS'(1'b1) << d_q);
        seg_n_d     = (alarm_active_q && !blink_off_s) ? 7'b0000000 : seg_decode(digit_s);
    end

    // State and output registers.
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            p_q            <= '0;
            c_q            <= '0;
            d_q            <= 3'd0;
            time_q         <= '0;
            tick_q         <= 1'b0;
            load_err_q     <= 1'b0;
            inc_q          <= 1'b0;
            alarm_hit_q    <= 1'b0;
            alarm_active_q <= 1'b0;
            an_n_q         <= {DIGITS{1'b1}};
            seg_n_q        <= 7'b1111111;
        end else begin
            p_q            <= p_d;
            c_q            <= c_d;
            d_q            <= d_d;
            time_q         <= time_d;
            tick_q         <= tick_d;
            load_err_q     <= load_err_d;
            inc_q          <= inc_d;
            alarm_hit_q    <= alarm_hit_d;
            alarm_active_q <= alarm_active_d;
            an_n_q         <= an_n_d;
            seg_n_q        <= seg_n_d;
        end
    end

    assign time_out_o     = time_q;
    assign tick_o         = tick_q;
    assign load_err_o     = load_err_q;
    assign alarm_hit_o    = alarm_hit_q;
    assign alarm_active_o = alarm_active_q;
    assign an_n_o         = an_n_q;
    assign seg_n_o        = seg_n_q;

endmodule

// File: tb/tb_bcd_time_display.sv
// Directed bench: a 4-digit and a 6-digit instance (TICK_DIV=4, SCAN_DIV=2)
// driven from a load/tick vector table plus hand-written multi-cycle sequences.
module tb_bcd_time_display;

    logic clk_osc = 1'b0;
    always #5 clk_osc = ~clk_osc;

    logic        reset, run;
    logic        load4, load6, aen4, ack4;
    logic [15:0] lv4, av4;
    logic [23:0] lv6, av6;
    logic [3:0]  bm4;
    logic [5:0]  bm6;

    logic [15:0] time4;
    logic [23:0] time6;
    logic        tick4, load_err4, hit4, active4;
    logic        tick6, load_err6, hit6, active6;
    logic [3:0]  an4;
    logic [5:0]  an6;
    logic [6:0]  seg4, seg6;

    bcd_time_display #(.TICK_DIV(4), .SCAN_DIV(2), .DIGITS(4)) dut4 (
        .clk_osc(clk_osc), .reset(reset), .run_i(run), .load_i(load4),
        .load_value_i(lv4), .alarm_value_i(av4), .alarm_en_i(aen4),
        .alarm_ack_i(ack4), .blink_mask_i(bm4), .time_out_o(time4),
        .tick_o(tick4), .load_err_o(load_err4), .alarm_hit_o(hit4),
        .alarm_active_o(active4), .an_n_o(an4), .seg_n_o(seg4)
    );

    bcd_time_display #(.TICK_DIV(4), .SCAN_DIV(2), .DIGITS(6)) dut6 (
        .clk_osc(clk_osc), .reset(reset), .run_i(run), .load_i(load6),
        .load_value_i(lv6), .alarm_value_i(av6), .alarm_en_i(1'b0),
        .alarm_ack_i(1'b0), .blink_mask_i(bm6), .time_out_o(time6),
        .tick_o(tick6), .load_err_o(load_err6), .alarm_hit_o(hit6),
        .alarm_active_o(active6), .an_n_o(an6), .seg_n_o(seg6)
    );

    typedef struct {
        logic        is6;
        logic [23:0] lv;
        int          ticks;
        logic        err;
        logic [23:0] t;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    int nt;
    int idx;
    logic [3:0] one4 = 4'b0001;
    logic [3:0] exp_an;
    logic [6:0] seg_exp [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_osc);
        #1;
        k++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 24'h005958, 1, 1'b0, 24'h005959};
        vecs[1]  = '{1'b0, 24'h005958, 2, 1'b0, 24'h000000};
        vecs[2]  = '{1'b0, 24'h001234, 0, 1'b0, 24'h001234};
        vecs[3]  = '{1'b0, 24'h000960, 0, 1'b1, 24'h001234};
        vecs[4]  = '{1'b0, 24'h006000, 0, 1'b1, 24'h001234};
        vecs[5]  = '{1'b0, 24'h000A00, 0, 1'b1, 24'h001234};
        vecs[6]  = '{1'b0, 24'h00000F, 0, 1'b1, 24'h001234};
        vecs[7]  = '{1'b0, 24'h000959, 1, 1'b0, 24'h001000};
        vecs[8]  = '{1'b1, 24'h235959, 1, 1'b0, 24'h000000};
        vecs[9]  = '{1'b1, 24'h091959, 1, 1'b0, 24'h092000};
        vecs[10] = '{1'b1, 24'h195959, 1, 1'b0, 24'h200000};
        vecs[11] = '{1'b1, 24'h240000, 0, 1'b1, 24'h200000};
        vecs[12] = '{1'b1, 24'h300000, 0, 1'b1, 24'h200000};
        vecs[13] = '{1'b1, 24'h230000, 0, 1'b0, 24'h230000};

        reset = 1'b1; run = 1'b0;
        load4 = 1'b0; load6 = 1'b0; lv4 = 16'h0000; lv6 = 24'h000000;
        av4 = 16'h0000; av6 = 24'h000000; aen4 = 1'b0; ack4 = 1'b0;
        bm4 = 4'b0000; bm6 = 6'b000000;

        repeat (3) step();
        check("rst_time4", time4, 16'h0000);
        check("rst_time6", time6, 24'h000000);
        check("rst_an4", an4, 4'hF);
        check("rst_seg4", seg4, 7'h7F);
        check("rst_tick4", tick4, 1'b0);
        check("rst_active4", active4, 1'b0);
        reset = 1'b0;
        step();

        // Load / tick vector table.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is6) begin
                load6 = 1'b1; lv6 = vecs[i].lv;
            end else begin
                load4 = 1'b1; lv4 = vecs[i].lv[15:0];
            end
            step();
            load4 = 1'b0; load6 = 1'b0;
            check($sformatf("vec%0d_err", i), vecs[i].is6 ? load_err6 : load_err4, vecs[i].err);
            step();
            check($sformatf("vec%0d_err_clear", i), vecs[i].is6 ? load_err6 : load_err4, 1'b0);
            run = (vecs[i].ticks > 0);
            nt = 0;
            for (int j = 0; j < 4 * vecs[i].ticks; j++) begin
                step();
                if (vecs[i].is6 ? tick6 : tick4) nt++;
            end
            run = 1'b0;
            check($sformatf("vec%0d_ticks", i), nt, vecs[i].ticks);
            check($sformatf("vec%0d_time", i), vecs[i].is6 ? time6 : {8'h00, time4}, vecs[i].t);
        end

        // Tick spacing: 59:58 -> 59:59 -> 00:00, pulses 4 cycles apart.
        load4 = 1'b1; lv4 = 16'h5958;
        step();
        load4 = 1'b0; run = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            check($sformatf("spacing_tick%0d", j), tick4, (j == 4) || (j == 8));
            if (j == 4) check("spacing_t5959", time4, 16'h5959);
            if (j == 8) check("spacing_t0000", time4, 16'h0000);
        end
        run = 1'b0;

        // Load coincident with a tick edge: load wins, tick still pulses.
        load4 = 1'b1; lv4 = 16'h1200;
        step();
        load4 = 1'b0; run = 1'b1;
        repeat (3) step();
        load4 = 1'b1; lv4 = 16'h3000;
        step();
        load4 = 1'b0;
        check("coinc_time", time4, 16'h3000);
        check("coinc_tick", tick4, 1'b1);
        check("coinc_err", load_err4, 1'b0);
        repeat (3) step();
        check("coinc_hold", time4, 16'h3000);
        step();
        check("coinc_next", time4, 16'h3001);
        check("coinc_next_tick", tick4, 1'b1);
        run = 1'b0;

        // Alarm on tick-caused match, no hit on load, ack clears.
        av4 = 16'h0005; aen4 = 1'b1;
        load4 = 1'b1; lv4 = 16'h0004;
        step();
        load4 = 1'b0;
        check("alarm_load_nohit", hit4, 1'b0);
        run = 1'b1;
        repeat (3) step();
        step();
        check("alarm_tick_time", time4, 16'h0005);
        check("alarm_hit_early", hit4, 1'b0);
        step();
        check("alarm_hit", hit4, 1'b1);
        check("alarm_active", active4, 1'b1);
        step();
        check("alarm_hit_pulse", hit4, 1'b0);
        check("alarm_active_hold", active4, 1'b1);
        run = 1'b0;
        av4 = 16'h0004;
        load4 = 1'b1; lv4 = 16'h0004;
        step();
        load4 = 1'b0;
        check("alarm_loadmatch_0", hit4, 1'b0);
        step();
        check("alarm_loadmatch_1", hit4, 1'b0);
        check("alarm_flash_seg", seg4, 7'b0000000);
        ack4 = 1'b1;
        step();
        ack4 = 1'b0; aen4 = 1'b0;
        check("alarm_ack", active4, 1'b0);

        // Reset mid-count and mid-scan takes effect without a clock edge.
        run = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        #1;
        check("midrst_time4", time4, 16'h0000);
        check("midrst_time6", time6, 24'h000000);
        check("midrst_tick", tick4, 1'b0);
        check("midrst_err", load_err4, 1'b0);
        check("midrst_hit", hit4, 1'b0);
        check("midrst_an", an4, 4'hF);
        check("midrst_seg", seg4, 7'h7F);
        run = 1'b0;
        step();
        reset = 1'b0;
        load4 = 1'b1; lv4 = 16'h1234;
        k = 0;
        step();
        load4 = 1'b0;

        // Scan: digit index advances every 2 cycles, display lags by one.
        for (int j = 2; j <= 9; j++) begin
            step();
            idx = ((k - 1) / 2) % 4;
            exp_an = ~(one4 << idx);
            check($sformatf("scan_an_k%0d", k), an4, exp_an);
            check($sformatf("scan_seg_k%0d", k), seg4, seg_exp[idx]);
        end

        // Advance p into the off phase, then freeze it with run=0.
        bm4 = 4'b0001; run = 1'b1;
        repeat (2) step();
        run = 1'b0;
        for (int j = 12; j <= 19; j++) begin
            step();
            idx = ((k - 1) / 2) % 4;
            exp_an = (idx == 0) ? 4'hF : ~(one4 << idx);
            check($sformatf("blink_an_k%0d", k), an4, exp_an);
            check($sformatf("blink_seg_k%0d", k), seg4, seg_exp[idx]);
        end
        check("frozen_time", time4, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
